// File: rtl/bus_sequencer_if.sv
// rtl/bus_sequencer_if.sv - requester handshakes and register-bus control for bus_sequencer
interface bus_sequencer_if #(
   parameter int SEL_W = 4
) ();
   logic                    req0_valid;
   logic [SEL_W-1:0]        req0_src;
   logic [SEL_W-1:0]        req0_dst;
   logic                    req0_ready;
   logic                    req1_valid;
   logic [SEL_W-1:0]        req1_src;
   logic [SEL_W-1:0]        req1_dst;
   logic                    req1_ready;
   logic [SEL_W-1:0]        bus_sel;
   logic [(1<<SEL_W)-1:0]   load_en;
   logic                    done;
   logic                    done_id;
   logic                    err;

   modport master (
      output req0_valid, req0_src, req0_dst, req1_valid, req1_src, req1_dst,
      input  req0_ready, req1_ready, bus_sel, load_en, done, done_id, err
   );

   modport slave (
      input  req0_valid, req0_src, req0_dst, req1_valid, req1_src, req1_dst,
      output req0_ready, req1_ready, bus_sel, load_en, done, done_id, err
   );
endinterface

// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - two-requester register transfer sequencer
// Arbitrates, drives the bus select, waits SETTLE_CYC cycles, then strobes one destination load.
module bus_sequencer #(
   parameter int SEL_W      = 4,
   parameter int SETTLE_CYC = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   bus_sequencer_if.slave  io_bus
);
   localparam int NDST = 1 << SEL_W;

   typedef enum logic [1:0] {IDLE, SETTLE, LOAD, REJECT} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_cnt;
   logic                r_prio1;
   logic [SEL_W-1:0]    r_bus_sel;
   logic [SEL_W-1:0]    r_dst;
   logic                r_id;
   logic [NDST-1:0]     r_load_en;
   logic                r_done;
   logic                r_err;
   logic                r_done_id;

   logic                w_idle;
   logic                w_gnt0;
   logic                w_gnt1;
   logic                w_acc;
   logic                w_legal;
   logic [SEL_W-1:0]    w_src;
   logic [SEL_W-1:0]    w_dst;

   function automatic logic f_legal(input logic [SEL_W-1:0] c);
      int unsigned v;
      v = 32'(c);
      return (v < 8) || (v == 9) || (v == 10);
   endfunction

   // r_prio1 set means req0 won the last handshake, so req1 wins a tie
   assign w_idle  = (r_state == IDLE) && !i_rst;
   assign w_gnt0  = w_idle && io_bus.req0_valid && (!io_bus.req1_valid || !r_prio1);
   assign w_gnt1  = w_idle && io_bus.req1_valid && (!io_bus.req0_valid || r_prio1);
   assign w_acc   = w_gnt0 || w_gnt1;
   assign w_src   = w_gnt1 ? io_bus.req1_src : io_bus.req0_src;
   assign w_dst   = w_gnt1 ? io_bus.req1_dst : io_bus.req0_dst;
   assign w_legal = f_legal(w_src) && f_legal(w_dst);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_acc) w_next = w_legal ? SETTLE : REJECT;
         SETTLE:  if (r_cnt == 4'd0) w_next = LOAD;
         LOAD:    w_next = IDLE;
         REJECT:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt     <= 4'd0;
         r_prio1   <= 1'b0;
         r_bus_sel <= '0;
         r_dst     <= '0;
         r_id      <= 1'b0;
         r_load_en <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_done_id <= 1'b0;
      end else begin
         r_load_en <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         if (w_acc) begin
            r_prio1 <= w_gnt0;
            r_id    <= w_gnt1;
            r_dst   <= w_dst;
            r_cnt   <= 4'(SETTLE_CYC - 1);
            if (w_legal) begin
               r_bus_sel <= w_src;
            end else begin
               r_err     <= 1'b1;
               r_done_id <= w_gnt1;
            end
         end else if (r_state == SETTLE) begin
            if (r_cnt == 4'd0) begin
               r_load_en <= NDST'(1) << r_dst;
               r_done    <= 1'b1;
               r_done_id <= r_id;
            end else begin
               r_cnt <= r_cnt - 4'd1;
            end
         end
      end
   end

   assign io_bus.req0_ready = w_gnt0;
   assign io_bus.req1_ready = w_gnt1;
   assign io_bus.bus_sel    = r_bus_sel;
   assign io_bus.load_en    = r_load_en;
   assign io_bus.done       = r_done;
   assign io_bus.done_id    = r_done_id;
   assign io_bus.err        = r_err;
endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - bench for bus_sequencer with SETTLE_CYC = 1, 2 and 3 instances
module tb_bus_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       v0 = 1'b0, v1 = 1'b0;
   logic [3:0] s0 = '0, d0 = '0, s1 = '0, d1 = '0;
   int         sel_k = 0;

   logic [2:0]       obs_r0, obs_r1, obs_done, obs_err, obs_id;
   logic [2:0][3:0]  obs_bus;
   logic [2:0][15:0] obs_load;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bus_sequencer_if #(.SEL_W(4)) bif ();
      assign bif.req0_valid = (sel_k == g) ? v0 : 1'b0;
      assign bif.req0_src   = s0;
      assign bif.req0_dst   = d0;
      assign bif.req1_valid = (sel_k == g) ? v1 : 1'b0;
      assign bif.req1_src   = s1;
      assign bif.req1_dst   = d1;
      assign obs_r0[g]   = bif.req0_ready;
      assign obs_r1[g]   = bif.req1_ready;
      assign obs_done[g] = bif.done;
      assign obs_err[g]  = bif.err;
      assign obs_id[g]   = bif.done_id;
      assign obs_bus[g]  = bif.bus_sel;
      assign obs_load[g] = bif.load_en;
      bus_sequencer #(.SEL_W(4), .SETTLE_CYC(g + 1)) u_dut (
         .i_clk  (clk),
         .i_rst  (rst),
         .io_bus (bif)
      );
   end

   int total = 0;
   int bad   = 0;

   // transaction-level reference: one transfer in flight, described by when it ends
   int         t = 0;
   int         free_at = 0;
   int         pend_at = -1;
   int         last = 1;
   bit         pend_err = 1'b0;
   bit         pend_id = 1'b0;
   logic [3:0] pend_dst = '0;
   logic [3:0] m_bus = '0;

   logic        e_r0, e_r1, e_done, e_err, e_id;
   logic [15:0] e_load;
   logic [3:0]  e_bus;

   function automatic bit legal(input logic [3:0] c);
      return c inside {[4'd0:4'd7], 4'd9, 4'd10};
   endfunction

   function automatic logic [3:0] rand_code();
      if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
      return 4'($urandom_range(0, 7));
   endfunction

   task automatic model_eval();
      bit idle;
      #1;
      idle   = (t >= free_at) && !rst;
      e_r0   = idle && v0 && (!v1 || last == 1);
      e_r1   = idle && v1 && (!v0 || last == 0);
      e_done = (t == pend_at) && !pend_err;
      e_err  = (t == pend_at) && pend_err;
      e_load = e_done ? (16'd1 << pend_dst) : 16'd0;
      e_id   = pend_id;
      e_bus  = m_bus;
   endtask

   task automatic tick();
      int s;
      model_eval();
      s = sel_k + 1;
      if (!rst && (e_r0 || e_r1)) begin
         logic [3:0] src, dst;
         bit         id;
         id       = e_r1;
         src      = id ? s1 : s0;
         dst      = id ? d1 : d0;
         last     = id ? 1 : 0;
         pend_id  = id;
         pend_dst = dst;
         if (legal(src) && legal(dst)) begin
            pend_err = 1'b0;
            pend_at  = t + 1 + s;
            free_at  = t + 2 + s;
            m_bus    = src;
         end else begin
            pend_err = 1'b1;
            pend_at  = t + 1;
            free_at  = t + 2;
         end
      end
      @(posedge clk);
      t++;
      if (rst) begin
         free_at = t;
         pend_at = -1;
         last    = 1;
         m_bus   = '0;
         pend_id = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input int k);
      sel_k = k;
      v0 = 1'b0;
      v1 = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      sel_k = 0;
      rst = 1'b1;
      v0 = 1'b1; s0 = 4'd1; d0 = 4'd2;
      v1 = 1'b1; s1 = 4'd3; d1 = 4'd4;
      tick();
      tick();
      #1;
      for (int k = 0; k < 3; k++) begin
         total++; if (obs_r0[k] !== 1'b0) begin bad++; $display("FAIL reset_ready0[%0d] got=%0h exp=0", k, obs_r0[k]); end
         total++; if (obs_r1[k] !== 1'b0) begin bad++; $display("FAIL reset_ready1[%0d] got=%0h exp=0", k, obs_r1[k]); end
         total++; if (obs_bus[k] !== 4'h0) begin bad++; $display("FAIL reset_bus_sel[%0d] got=%0h exp=0", k, obs_bus[k]); end
         total++; if (obs_load[k] !== 16'h0) begin bad++; $display("FAIL reset_load_en[%0d] got=%0h exp=0", k, obs_load[k]); end
         total++; if ({obs_done[k], obs_err[k], obs_id[k]} !== 3'b000) begin bad++; $display("FAIL reset_done_err_id[%0d] got=%0b exp=000", k, {obs_done[k], obs_err[k], obs_id[k]}); end
      end
      rst = 1'b0;
      v0 = 1'b0;
      v1 = 1'b0;
   endtask

   task automatic test_basic();
      do_reset(0);
      v0 = 1'b1; s0 = 4'b0110; d0 = 4'b0011;
      model_eval();
      total++; if (obs_r0[0] !== 1'b1) begin bad++; $display("FAIL basic_ready0 got=%0h exp=1", obs_r0[0]); end
      tick();
      v0 = 1'b0;
      model_eval();
      total++; if (obs_bus[0] !== 4'b0110) begin bad++; $display("FAIL basic_bus_sel got=%0h exp=6", obs_bus[0]); end
      total++; if ({obs_load[0], obs_done[0]} !== 17'h0) begin bad++; $display("FAIL basic_early_load got=%0h exp=0", {obs_load[0], obs_done[0]}); end
      tick();
      v1 = 1'b1; s1 = 4'd5; d1 = 4'd5;
      model_eval();
      total++; if (obs_load[0] !== 16'h0008) begin bad++; $display("FAIL basic_load_en got=%0h exp=0008", obs_load[0]); end
      total++; if ({obs_done[0], obs_id[0], obs_err[0]} !== 3'b100) begin bad++; $display("FAIL basic_done_id_err got=%0b exp=100", {obs_done[0], obs_id[0], obs_err[0]}); end
      total++; if (obs_r1[0] !== 1'b0) begin bad++; $display("FAIL basic_ready_in_load got=%0h exp=0", obs_r1[0]); end
      tick();
      model_eval();
      total++; if ({obs_load[0], obs_done[0]} !== 17'h0) begin bad++; $display("FAIL basic_pulse_width got=%0h exp=0", {obs_load[0], obs_done[0]}); end
      total++; if (obs_r1[0] !== 1'b1) begin bad++; $display("FAIL basic_ready_after_load got=%0h exp=1", obs_r1[0]); end
      tick();
      v1 = 1'b0;
      tick();
      model_eval();
      total++; if (obs_load[0] !== 16'h0020 || obs_done[0] !== 1'b1 || obs_id[0] !== 1'b1) begin bad++; $display("FAIL basic_same_src_dst got=%0h/%0b/%0b exp=0020/1/1", obs_load[0], obs_done[0], obs_id[0]); end
      tick();
   endtask

   task automatic test_round_robin();
      int gnt[$];
      do_reset(0);
      v0 = 1'b1; s0 = 4'($urandom_range(0, 7)); d0 = 4'($urandom_range(0, 7));
      v1 = 1'b1; s1 = 4'($urandom_range(0, 7)); d1 = 4'($urandom_range(0, 7));
      for (int n = 0; n < 60 && gnt.size() < 6; n++) begin
         model_eval();
         total++; if (obs_r0[0] !== e_r0 || obs_r1[0] !== e_r1) begin bad++; $display("FAIL rr_ready cyc=%0d got=%0b%0b exp=%0b%0b", n, obs_r0[0], obs_r1[0], e_r0, e_r1); end
         if (obs_r0[0] === 1'b1) gnt.push_back(0);
         if (obs_r1[0] === 1'b1) gnt.push_back(1);
         tick();
         s0 = 4'($urandom_range(0, 7)); d0 = 4'($urandom_range(0, 7));
         s1 = 4'($urandom_range(0, 7)); d1 = 4'($urandom_range(0, 7));
      end
      total++; if (gnt.size() < 6) begin bad++; $display("FAIL rr_grant_count got=%0d exp=6", gnt.size()); end
      for (int i = 0; i < gnt.size(); i++) begin
         total++; if (gnt[i] != i % 2) begin bad++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, gnt[i], i % 2); end
      end
      v0 = 1'b0;
      v1 = 1'b0;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_illegal();
      do_reset(0);
      v0 = 1'b1; s0 = 4'd2; d0 = 4'd7;
      tick();
      v0 = 1'b0;
      tick();
      tick();
      v1 = 1'b1; s1 = 4'b1000; d1 = 4'd1;
      model_eval();
      total++; if (obs_r1[0] !== 1'b1) begin bad++; $display("FAIL illegal_ready1 got=%0h exp=1", obs_r1[0]); end
      tick();
      v1 = 1'b0;
      model_eval();
      total++; if (obs_err[0] !== 1'b1 || obs_id[0] !== 1'b1) begin bad++; $display("FAIL illegal_err_id got=%0b%0b exp=11", obs_err[0], obs_id[0]); end
      total++; if (obs_load[0] !== 16'h0 || obs_done[0] !== 1'b0) begin bad++; $display("FAIL illegal_load got=%0h/%0b exp=0/0", obs_load[0], obs_done[0]); end
      total++; if (obs_bus[0] !== 4'd2) begin bad++; $display("FAIL illegal_bus_hold got=%0h exp=2", obs_bus[0]); end
      tick();
      v0 = 1'b1; s0 = 4'd1; d0 = 4'hF;
      model_eval();
      total++; if (obs_err[0] !== 1'b0 || obs_r0[0] !== 1'b1) begin bad++; $display("FAIL illegal_recover got=%0b%0b exp=01", obs_err[0], obs_r0[0]); end
      tick();
      v0 = 1'b0;
      model_eval();
      total++; if (obs_err[0] !== 1'b1 || obs_id[0] !== 1'b0 || obs_bus[0] !== 4'd2) begin bad++; $display("FAIL illegal_dst got=%0b/%0b/%0h exp=1/0/2", obs_err[0], obs_id[0], obs_bus[0]); end
      tick();
   endtask

   task automatic test_long_settle();
      do_reset(2);
      v0 = 1'b1; s0 = 4'b1010; d0 = 4'b0000;
      model_eval();
      total++; if (obs_r0[2] !== 1'b1) begin bad++; $display("FAIL settle3_ready0 got=%0h exp=1", obs_r0[2]); end
      tick();
      s0 = 4'd3; d0 = 4'd4;
      for (int i = 0; i < 3; i++) begin
         model_eval();
         total++; if (obs_r0[2] !== 1'b0) begin bad++; $display("FAIL settle3_busy_ready cyc=%0d got=%0h exp=0", i, obs_r0[2]); end
         total++; if (obs_bus[2] !== 4'b1010) begin bad++; $display("FAIL settle3_bus cyc=%0d got=%0h exp=a", i, obs_bus[2]); end
         total++; if (obs_load[2] !== 16'h0 || obs_done[2] !== 1'b0) begin bad++; $display("FAIL settle3_early_load cyc=%0d got=%0h exp=0", i, obs_load[2]); end
         tick();
      end
      model_eval();
      total++; if (obs_load[2] !== 16'h0001 || obs_done[2] !== 1'b1 || obs_r0[2] !== 1'b0) begin bad++; $display("FAIL settle3_load got=%0h/%0b/%0b exp=0001/1/0", obs_load[2], obs_done[2], obs_r0[2]); end
      tick();
      model_eval();
      total++; if (obs_r0[2] !== 1'b1 || obs_load[2] !== 16'h0) begin bad++; $display("FAIL settle3_next_ready got=%0b/%0h exp=1/0", obs_r0[2], obs_load[2]); end
      v0 = 1'b0;
      tick();
   endtask

   task automatic test_reset_abort();
      do_reset(1);
      v0 = 1'b1; s0 = 4'd5; d0 = 4'd6;
      tick();
      v0 = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         model_eval();
         total++; if ({obs_load[1], obs_done[1], obs_err[1], obs_bus[1]} !== 23'h0) begin bad++; $display("FAIL abort_quiet cyc=%0d got=%0h exp=0", i, {obs_load[1], obs_done[1], obs_err[1], obs_bus[1]}); end
         tick();
      end
      v1 = 1'b1; s1 = 4'd7; d1 = 4'd9;
      model_eval();
      total++; if (obs_r1[1] !== 1'b1) begin bad++; $display("FAIL abort_req1_ready got=%0h exp=1", obs_r1[1]); end
      tick();
      v1 = 1'b0;
      tick();
      tick();
      model_eval();
      total++; if (obs_load[1] !== 16'h0200 || obs_done[1] !== 1'b1 || obs_id[1] !== 1'b1 || obs_bus[1] !== 4'd7) begin bad++; $display("FAIL abort_req1_load got=%0h/%0b/%0b/%0h exp=0200/1/1/7", obs_load[1], obs_done[1], obs_id[1], obs_bus[1]); end
      tick();
   endtask

   task automatic test_random(input int k);
      bit h0, h1;
      h0 = 1'b0;
      h1 = 1'b0;
      do_reset(k);
      for (int n = 0; n < 250; n++) begin
         if (!h0 && $urandom_range(0, 2) == 0) begin h0 = 1'b1; s0 = rand_code(); d0 = rand_code(); end
         if (!h1 && $urandom_range(0, 2) == 0) begin h1 = 1'b1; s1 = rand_code(); d1 = rand_code(); end
         v0 = h0;
         v1 = h1;
         model_eval();
         total++; if (obs_r0[k] !== e_r0 || obs_r1[k] !== e_r1) begin bad++; $display("FAIL rand%0d_ready cyc=%0d got=%0b%0b exp=%0b%0b", k, n, obs_r0[k], obs_r1[k], e_r0, e_r1); end
         total++; if (obs_load[k] !== e_load || obs_done[k] !== e_done || obs_err[k] !== e_err) begin bad++; $display("FAIL rand%0d_pulse cyc=%0d got=%0h/%0b/%0b exp=%0h/%0b/%0b", k, n, obs_load[k], obs_done[k], obs_err[k], e_load, e_done, e_err); end
         total++; if (obs_bus[k] !== e_bus) begin bad++; $display("FAIL rand%0d_bus cyc=%0d got=%0h exp=%0h", k, n, obs_bus[k], e_bus); end
         if (e_done || e_err) begin
            total++; if (obs_id[k] !== e_id) begin bad++; $display("FAIL rand%0d_done_id cyc=%0d got=%0b exp=%0b", k, n, obs_id[k], e_id); end
         end
         if (e_r0) h0 = 1'b0;
         if (e_r1) h1 = 1'b0;
         tick();
      end
      v0 = 1'b0;
      v1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_illegal();
      test_long_settle();
      test_reset_abort();
      for (int k = 0; k < 3; k++) test_random(k);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
